full_subtractor: RTL and testbench

//  Registered WIDTH-bit ripple-borrow subtractor: computes x - y - borrowIn.

---
 rtl/full_sub_pkg.sv | 15 +
 rtl/full_sub_cell.sv | 19 +
 rtl/full_subtractor.sv | 76 +++++++
 tb/tb_full_subtractor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/full_sub_pkg.sv
// Shared definitions for the full subtractor.
//   MAX_WIDTH     widest operand the subtractor supports
//   STAGES        register stages from operands to outputs
//   sub_result_t  difference plus borrow, at full width
package full_sub_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int STAGES    = 1;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] diff;
    logic                 borrow;
  } sub_result_t;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor cell, purely combinational.
//   x, y       minuend and subtrahend bits
//   borrowIn   borrow from the next less significant bit
//   xy         difference bit
//   borrowOut  borrow into the next more significant bit
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic borrowIn,
  output logic xy,
  output logic borrowOut
);

  assign xy        = x ^ y ^ borrowIn;
  // A borrow is needed when the minuend bit is 0 and exactly one of y and
  // borrowIn is set, or when y and borrowIn are both set.
  assign borrowOut = (~x & (y ^ borrowIn)) | (y & borrowIn);

endmodule

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit ripple-borrow subtractor: xy = x - y - borrowIn.
//   clk, rst_n  clock and asynchronous active-low reset
//   in_valid    operands valid; the result is captured at this edge
//   x, y        minuend and subtrahend (WIDTH bits)
//   borrowIn    borrow into bit 0
//   out_valid   xy/borrowOut were updated at the last edge
//   xy          difference mod 2^WIDTH
//   borrowOut   borrow out of the MSB (unsigned x < y + borrowIn)
//   overflow    signed overflow; exists only when FULL_SUB_OVF_EN is defined
// Optional feature macro: FULL_SUB_OVF_EN
module full_subtractor
  import full_sub_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrowIn,
  output logic             out_valid,
  output logic [WIDTH-1:0] xy,
  output logic             borrowOut
`ifdef FULL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  // Borrow chain: b[0] is the external borrow, b[WIDTH] leaves the MSB.
  logic [WIDTH:0]   b;
  logic [WIDTH-1:0] d;
  logic [STAGES:1]  vld_pipe;

  assign b[0] = borrowIn;

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    full_sub_cell uCell (
      .x        (x[i]),
      .y        (y[i]),
      .borrowIn (b[i]),
      .xy       (d[i]),
      .borrowOut(b[i+1])
    );
  end

  // Data registers load only under in_valid, so operand X/Z on idle
  // cycles never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xy        <= '0;
      borrowOut <= 1'b0;
    end else if (in_valid) begin
      xy        <= d;
      borrowOut <= b[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe[1] <= in_valid;
  end

  assign out_valid = vld_pipe[STAGES];

`ifdef FULL_SUB_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  // For WIDTH=1 the borrow into the sign bit is borrowIn itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        overflow <= 1'b0;
    else if (in_valid) overflow <= b[WIDTH] ^ b[WIDTH-1];
  end
`endif

endmodule

// File: tb/tb_full_subtractor.sv
module tb_full_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       v1, x1, y1, bi1;
  logic       ov1, xy1, bo1;

  logic       v8, bi8;
  logic [7:0] x8, y8;
  logic       ov8, bo8;
  logic [7:0] xy8;

`ifdef FULL_SUB_OVF_EN
  logic       of1, of8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .x(x1), .y(y1), .borrowIn(bi1),
    .out_valid(ov1), .xy(xy1), .borrowOut(bo1)
`ifdef FULL_SUB_OVF_EN
    , .overflow(of1)
`endif
  );

  full_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .x(x8), .y(y8), .borrowIn(bi8),
    .out_valid(ov8), .xy(xy8), .borrowOut(bo8)
`ifdef FULL_SUB_OVF_EN
    , .overflow(of8)
`endif
  );

  // Drive the 8-bit DUT at a falling edge, then sample 1ns after the rising edge.
  task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic v);
    @(negedge clk);
    x8 = a; y8 = b; bi8 = bi; v8 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    v1 = 0; x1 = 0; y1 = 0; bi1 = 0;
    v8 = 0; x8 = 0; y8 = 0; bi8 = 0;
    #12;
    checks++;
    if ({ov8, xy8, bo8} !== 10'b0) begin
      failures++;
      $display("FAIL reset_w8 got ov=%b xy=%h bo=%b want 0 00 0", ov8, xy8, bo8);
    end
    checks++;
    if ({ov1, xy1, bo1} !== 3'b0) begin
      failures++;
      $display("FAIL reset_w1 got ov=%b xy=%b bo=%b want 000", ov1, xy1, bo1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive_w1;
    logic [1:0] exp1 [8];
    logic [2:0] v;
    exp1 = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      {x1, y1, bi1} = v; v1 = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({xy1, bo1} !== exp1[i] || ov1 !== 1'b1) begin
        failures++;
        $display("FAIL w1_sweep in=%b got xy,bo=%b%b ov=%b want %b ov=1", v, xy1, bo1, ov1, exp1[i]);
      end
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic test_basic;
    step8(8'h05, 8'h03, 1'b0, 1'b1);
    checks++;
    if (xy8 !== 8'h02 || bo8 !== 1'b0 || ov8 !== 1'b1) begin
      failures++;
      $display("FAIL basic_05_03 got xy=%h bo=%b ov=%b want 02 0 1", xy8, bo8, ov8);
    end
  endtask

  task automatic test_wrap;
    step8(8'h00, 8'h01, 1'b0, 1'b1);
    checks++;
    if (xy8 !== 8'hFF || bo8 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_00_01 got xy=%h bo=%b want FF 1", xy8, bo8);
    end
    step8(8'h00, 8'hFF, 1'b1, 1'b1);
    checks++;
    if (xy8 !== 8'h00 || bo8 !== 1'b1) begin
      failures++;
      $display("FAIL fullscale got xy=%h bo=%b want 00 1", xy8, bo8);
    end
  endtask

  task automatic test_hold;
    step8(8'h00, 8'h01, 1'b0, 1'b1);
    step8(8'h33, 8'h11, 1'b0, 1'b0);
    checks++;
    if (xy8 !== 8'hFF || bo8 !== 1'b1 || ov8 !== 1'b0) begin
      failures++;
      $display("FAIL hold got xy=%h bo=%b ov=%b want FF 1 0", xy8, bo8, ov8);
    end
    // Unknown operands while idle must not reach the registers.
    step8(8'hxx, 8'hzz, 1'bx, 1'b0);
    checks++;
    if (xy8 !== 8'hFF || bo8 !== 1'b1 || ov8 !== 1'b0) begin
      failures++;
      $display("FAIL hold_x got xy=%h bo=%b ov=%b want FF 1 0", xy8, bo8, ov8);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] xa [3];
    logic [7:0] ya [3];
    logic       ba [3];
    logic [8:0] ex [3];
    xa = '{8'h20, 8'h10, 8'hFF};
    ya = '{8'h10, 8'h20, 8'hFF};
    ba = '{1'b0, 1'b0, 1'b1};
    ex = '{{8'h10, 1'b0}, {8'hF0, 1'b1}, {8'hFF, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      step8(xa[i], ya[i], ba[i], 1'b1);
      checks++;
      if ({xy8, bo8} !== ex[i] || ov8 !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d] got xy=%h bo=%b ov=%b want %h %b 1", i, xy8, bo8, ov8, ex[i][8:1], ex[i][0]);
      end
    end
    step8(8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (ov8 !== 1'b0 || xy8 !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_end got ov=%b xy=%h want 0 FF", ov8, xy8);
    end
  endtask

  task automatic test_midreset;
    step8(8'h00, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    v8 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (xy8 !== 8'h00 || bo8 !== 1'b0 || ov8 !== 1'b0) begin
      failures++;
      $display("FAIL midreset got xy=%h bo=%b ov=%b want 00 0 0", xy8, bo8, ov8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step8(8'h10, 8'h01, 1'b0, 1'b1);
    checks++;
    if (xy8 !== 8'h0F || bo8 !== 1'b0 || ov8 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset got xy=%h bo=%b ov=%b want 0F 0 1", xy8, bo8, ov8);
    end
  endtask

`ifdef FULL_SUB_OVF_EN
  task automatic test_overflow;
    step8(8'h80, 8'h01, 1'b0, 1'b1);
    checks++;
    if (xy8 !== 8'h7F || of8 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_80_01 got xy=%h of=%b want 7F 1", xy8, of8);
    end
    step8(8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (of8 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_hold got of=%b want 1", of8);
    end
    step8(8'h7F, 8'h01, 1'b0, 1'b1);
    checks++;
    if (xy8 !== 8'h7E || of8 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_7F_01 got xy=%h of=%b want 7E 0", xy8, of8);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exhaustive_w1();
    test_basic();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_midreset();
`ifdef FULL_SUB_OVF_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
